// File: rtl/fpu_req_scheduler_pkg.sv
// Shared FPU definitions: op encodings, default scheduler sizing and bus payload types.
package fpu_req_scheduler_pkg;

   localparam int unsigned DATA_W        = 32;
   localparam int unsigned OP_W          = 2;
   localparam int unsigned NUM_REQ       = 2;
   localparam int unsigned TAG_W         = 1;
   localparam int unsigned LATENCY_DEF   = 4;
   localparam int unsigned RSP_DEPTH_DEF = 2;

   typedef enum logic [OP_W-1:0] {
      OP_ADD  = 2'b00,
      OP_SUB  = 2'b01,
      OP_MUL  = 2'b10,
      OP_RSVD = 2'b11
   } fpu_op_e;

   typedef struct packed {
      logic [OP_W-1:0]   op;
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
   } fpu_req_t;

   typedef struct packed {
      logic             vld;
      logic [TAG_W-1:0] tag;
   } pipe_tag_t;

endpackage

// File: rtl/fpu_rsp_fifo.sv
// Small per-requester response FIFO; head is exposed combinationally.
module fpu_rsp_fifo #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             empty
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             full;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign empty  = (count == '0);
   assign full   = (count == CNT_W'(DEPTH));
   assign do_pop = pop & ~empty;
   assign head   = mem[rd_ptr];

   // Storage carries no reset; validity is tracked by count.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)   wr_ptr <= ptr_inc(wr_ptr);
         if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
         case ({push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Credits upstream must make an overflowing push impossible.
   a_no_overflow: assert property (@(posedge clk) disable iff (!reset) !(push && full && !do_pop));

endmodule

// File: rtl/fpu_req_scheduler.sv
// Two-requester round-robin scheduler in front of a shared fixed-latency FPU pipeline.
module fpu_req_scheduler
   import fpu_req_scheduler_pkg::*;
#(
   parameter int unsigned LATENCY   = LATENCY_DEF,
   parameter int unsigned RSP_DEPTH = RSP_DEPTH_DEF
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [NUM_REQ-1:0]              req_valid,
   output logic [NUM_REQ-1:0]              req_ready,
   input  logic [NUM_REQ-1:0][OP_W-1:0]    req_op,
   input  logic [NUM_REQ-1:0][DATA_W-1:0]  req_a,
   input  logic [NUM_REQ-1:0][DATA_W-1:0]  req_b,
   output logic                            alu_valid,
   output logic [OP_W-1:0]                 alu_op,
   output logic [DATA_W-1:0]               alu_a,
   output logic [DATA_W-1:0]               alu_b,
   input  logic [DATA_W-1:0]               alu_result,
   output logic [NUM_REQ-1:0]              rsp_valid,
   input  logic [NUM_REQ-1:0]              rsp_ready,
   output logic [NUM_REQ-1:0][DATA_W-1:0]  rsp_data,
   output logic                            busy
);

   localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);

   logic [NUM_REQ-1:0] eligible;
   logic [NUM_REQ-1:0] grant;
   logic [NUM_REQ-1:0] push;
   logic [NUM_REQ-1:0] pop;
   logic [NUM_REQ-1:0] fifo_empty;
   logic [CNT_W-1:0]   outstanding [NUM_REQ];
   logic               rr_ptr;
   logic               gnt_idx;
   logic               alu_tag;
   pipe_tag_t          pipe [LATENCY];
   fpu_req_t           sel_req;

   // Credit-gated round-robin grant; the pointer only matters under contention.
   always_comb begin
      eligible = '0;
      for (int i = 0; i < NUM_REQ; i++)
         eligible[i] = reset & req_valid[i] & (outstanding[i] < CNT_W'(RSP_DEPTH));
      grant = eligible;
      if (&eligible) grant = rr_ptr ? 2'b10 : 2'b01;
      gnt_idx = grant[1];
      sel_req = '{op: req_op[gnt_idx], a: req_a[gnt_idx], b: req_b[gnt_idx]};
   end

   assign req_ready = grant;

   always_comb begin
      busy = 1'b0;
      for (int i = 0; i < NUM_REQ; i++)
         if (outstanding[i] != '0) busy = 1'b1;
   end

   // Registered issue; payload holds when idle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         alu_valid <= 1'b0;
         alu_tag   <= 1'b0;
         alu_op    <= '0;
         alu_a     <= '0;
         alu_b     <= '0;
         rr_ptr    <= 1'b0;
      end else begin
         alu_valid <= |grant;
         if (|grant) begin
            alu_tag <= gnt_idx;
            alu_op  <= sel_req.op;
            alu_a   <= sel_req.a;
            alu_b   <= sel_req.b;
            rr_ptr  <= ~rr_ptr;
         end
      end
   end

   // Tag pipeline tracks alu_valid so its tail lines up with alu_result.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int k = 0; k < LATENCY; k++) pipe[k] <= '0;
      end else begin
         pipe[0] <= '{vld: alu_valid, tag: alu_tag};
         for (int k = 1; k < LATENCY; k++) pipe[k] <= pipe[k-1];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_REQ; i++) outstanding[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            case ({grant[i], pop[i]})
               2'b10:   outstanding[i] <= outstanding[i] + CNT_W'(1);
               2'b01:   outstanding[i] <= outstanding[i] - CNT_W'(1);
               default: outstanding[i] <= outstanding[i];
            endcase
         end
      end
   end

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_rsp
      assign push[g]      = pipe[LATENCY-1].vld & (pipe[LATENCY-1].tag == TAG_W'(g));
      assign rsp_valid[g] = ~fifo_empty[g];
      assign pop[g]       = rsp_valid[g] & rsp_ready[g];

      fpu_rsp_fifo #(
         .DEPTH (RSP_DEPTH),
         .WIDTH (DATA_W)
      ) u_fifo (
         .clk       (clk),
         .reset     (reset),
         .push      (push[g]),
         .push_data (alu_result),
         .pop       (pop[g]),
         .head      (rsp_data[g]),
         .empty     (fifo_empty[g])
      );
   end

endmodule

// File: tb/tb_fpu_req_scheduler.sv
// Randomized and directed bench for fpu_req_scheduler against a queue-based reference model.
module tb_fpu_req_scheduler;
   import fpu_req_scheduler_pkg::*;

   localparam int unsigned LAT   = 4;
   localparam int unsigned DEPTH = 2;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic [1:0]       req_valid;
   logic [1:0]       req_ready;
   logic [1:0][1:0]  req_op;
   logic [1:0][31:0] req_a;
   logic [1:0][31:0] req_b;
   logic             alu_valid;
   logic [1:0]       alu_op;
   logic [31:0]      alu_a;
   logic [31:0]      alu_b;
   logic [31:0]      alu_result;
   logic [1:0]       rsp_valid;
   logic [1:0]       rsp_ready;
   logic [1:0][31:0] rsp_data;
   logic             busy;

   fpu_req_scheduler #(.LATENCY(LAT), .RSP_DEPTH(DEPTH)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .req_a      (req_a),
      .req_b      (req_b),
      .alu_valid  (alu_valid),
      .alu_op     (alu_op),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_result (alu_result),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_data   (rsp_data),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // Stand-in FPU: a deterministic function of its inputs, delivered LAT cycles after issue.
   function automatic logic [31:0] alu_fn(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      if (op == 2'b00 && a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
      return (a ^ {b[15:0], b[31:16]}) + ({30'd0, op} * 32'h0100_0193);
   endfunction

   logic [31:0] alu_sh [LAT];
   always @(posedge clk) begin
      alu_sh[0] <= alu_fn(alu_op, alu_a, alu_b);
      for (int k = 1; k < LAT; k++) alu_sh[k] <= alu_sh[k-1];
   end
   assign alu_result = alu_sh[LAT-1];

   typedef struct {
      logic [31:0] data;
      int          vis;
   } rsp_t;

   rsp_t        exp_q [2][$];
   int          n_chk = 0;
   int          n_err = 0;
   int          cyc = 0;
   int          m_out [2];
   bit          m_ptr;
   bit          pend_issue;
   logic [1:0]  pend_op, last_op;
   logic [31:0] pend_a, pend_b, last_a, last_b;
   int          acc_cnt [2];

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Reference model: credits, round-robin pointer and per-requester result queues.
   always @(negedge clk) begin
      logic [1:0] elig, exp_g, exp_v;
      rsp_t       r;
      if (!reset) begin
         check_eq("rst_req_ready", 64'(req_ready), 64'd0);
         check_eq("rst_alu_valid", 64'(alu_valid), 64'd0);
         check_eq("rst_alu_op",    64'(alu_op), 64'd0);
         check_eq("rst_alu_a",     64'(alu_a), 64'd0);
         check_eq("rst_alu_b",     64'(alu_b), 64'd0);
         check_eq("rst_rsp_valid", 64'(rsp_valid), 64'd0);
         check_eq("rst_busy",      64'(busy), 64'd0);
         for (int i = 0; i < 2; i++) begin
            exp_q[i].delete();
            m_out[i] = 0;
         end
         m_ptr = 1'b0;
         pend_issue = 1'b0;
         last_op = '0; last_a = '0; last_b = '0;
      end else begin
         check_eq("alu_valid", 64'(alu_valid), 64'(pend_issue));
         if (pend_issue) begin
            last_op = pend_op; last_a = pend_a; last_b = pend_b;
         end
         check_eq("alu_op", 64'(alu_op), 64'(last_op));
         check_eq("alu_a",  64'(alu_a),  64'(last_a));
         check_eq("alu_b",  64'(alu_b),  64'(last_b));
         for (int i = 0; i < 2; i++) elig[i] = req_valid[i] && (m_out[i] < DEPTH);
         if (elig == 2'b11) exp_g = m_ptr ? 2'b10 : 2'b01;
         else               exp_g = elig;
         check_eq("req_ready", 64'(req_ready), 64'(exp_g));
         for (int i = 0; i < 2; i++) begin
            exp_v[i] = (exp_q[i].size() > 0) && (exp_q[i][0].vis <= cyc);
            check_eq("rsp_valid", 64'(rsp_valid[i]), 64'(exp_v[i]));
            if (exp_v[i]) check_eq("rsp_data", 64'(rsp_data[i]), 64'(exp_q[i][0].data));
         end
         check_eq("busy", 64'(busy), 64'((m_out[0] + m_out[1]) != 0));
         for (int i = 0; i < 2; i++)
            if (req_ready[i] && req_valid[i]) acc_cnt[i]++;
         pend_issue = (exp_g != 2'b00);
         for (int i = 0; i < 2; i++) begin
            if (exp_g[i]) begin
               pend_op = req_op[i]; pend_a = req_a[i]; pend_b = req_b[i];
               r.data = alu_fn(req_op[i], req_a[i], req_b[i]);
               r.vis  = cyc + LAT + 2;
               exp_q[i].push_back(r);
               m_out[i]++;
               m_ptr = !m_ptr;
            end
         end
         for (int i = 0; i < 2; i++) begin
            if (exp_v[i] && rsp_ready[i]) begin
               void'(exp_q[i].pop_front());
               m_out[i]--;
            end
         end
      end
      cyc++;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic rand_payload();
      for (int i = 0; i < 2; i++) begin
         req_op[i] = 2'($urandom_range(0, 3));
         req_a[i]  = $urandom;
         req_b[i]  = $urandom;
      end
   endtask

   task automatic drain(input int n);
      req_valid = 2'b00;
      rsp_ready = 2'b11;
      repeat (n) step();
   endtask

   int lat;

   initial begin
      req_valid = 2'b11;
      rsp_ready = 2'b00;
      rand_payload();
      acc_cnt[0] = 0;
      acc_cnt[1] = 0;
      #1 reset = 1'b0;
      repeat (3) step();
      reset = 1'b1;
      req_valid = 2'b00;
      rsp_ready = 2'b11;
      step();

      // Single add on requester 0: issue at cycle 1, response at cycle 6.
      req_valid = 2'b01;
      req_op[0] = 2'b00;
      req_a[0]  = 32'h3F80_0000;
      req_b[0]  = 32'h4000_0000;
      #1 check_eq("single_ready", 64'(req_ready), 64'd1);
      step();
      req_valid = 2'b00;
      check_eq("single_issue", 64'({alu_valid, alu_op, alu_a, alu_b[31:0]} >> 32),
               64'({1'b1, 2'b00, 32'h3F80_0000}));
      lat = 1;
      while (!rsp_valid[0] && lat < 12) begin
         step();
         lat++;
      end
      check_eq("single_latency", 64'(lat), 64'd6);
      check_eq("single_data", 64'(rsp_data[0]), 64'h4040_0000);
      drain(4);

      // Contention with both requesters always valid.
      for (int c = 0; c < 24; c++) begin
         req_valid = 2'b11;
         rsp_ready = 2'b11;
         rand_payload();
         step();
      end
      drain(12);

      // Credit stall on requester 1.
      acc_cnt[0] = 0;
      acc_cnt[1] = 0;
      for (int c = 0; c < 20; c++) begin
         req_valid = 2'b11;
         rsp_ready = 2'b01;
         rand_payload();
         step();
      end
      check_eq("stall_acc1", 64'(acc_cnt[1]), 64'd2);
      check_eq("stall_ready1", 64'(req_ready[1]), 64'd0);
      check_eq("stall_req0_served", 64'(acc_cnt[0] >= 4), 64'd1);
      for (int c = 0; c < 12; c++) begin
         req_valid = 2'b11;
         rsp_ready = 2'b11;
         rand_payload();
         step();
      end
      check_eq("stall_resumed", 64'(acc_cnt[1] > 2), 64'd1);
      drain(12);

      // Back-to-back on requester 0: pop and push coincide at cycle 6.
      req_valid = 2'b01;
      req_op[0] = 2'b01; req_a[0] = 32'h0000_1111; req_b[0] = 32'h2222_0000;
      step();
      req_op[0] = 2'b10; req_a[0] = 32'h0000_3333; req_b[0] = 32'h4444_0000;
      step();
      req_valid = 2'b00;
      repeat (4) step();
      check_eq("pp_first_valid", 64'(rsp_valid[0]), 64'd1);
      check_eq("pp_first_data", 64'(rsp_data[0]), 64'(alu_fn(2'b01, 32'h0000_1111, 32'h2222_0000)));
      step();
      check_eq("pp_second_valid", 64'(rsp_valid[0]), 64'd1);
      check_eq("pp_second_data", 64'(rsp_data[0]), 64'(alu_fn(2'b10, 32'h0000_3333, 32'h4444_0000)));
      step();
      check_eq("pp_empty", 64'(rsp_valid[0]), 64'd0);
      drain(4);

      // Reserved op passes through untouched.
      req_valid = 2'b10;
      req_op[1] = 2'b11; req_a[1] = 32'hDEAD_BEEF; req_b[1] = 32'h1234_5678;
      step();
      req_valid = 2'b00;
      check_eq("rsvd_issue", 64'({alu_valid, alu_op}), 64'({1'b1, 2'b11}));
      drain(10);

      // Random traffic.
      for (int c = 0; c < 400; c++) begin
         req_valid = 2'($urandom);
         rsp_ready = 2'($urandom_range(0, 3));
         rand_payload();
         step();
      end
      drain(12);

      // Reset two cycles after an issue.
      req_valid = 2'b01;
      rand_payload();
      step();
      step();
      #1 reset = 1'b0;
      #1;
      check_eq("midrst_alu_valid", 64'(alu_valid), 64'd0);
      check_eq("midrst_alu_a", 64'(alu_a), 64'd0);
      check_eq("midrst_req_ready", 64'(req_ready), 64'd0);
      check_eq("midrst_busy", 64'(busy), 64'd0);
      step();
      step();
      reset = 1'b1;
      req_valid = 2'b00;
      for (int c = 0; c < 12; c++) begin
         step();
         check_eq("postrst_rsp_valid", 64'(rsp_valid), 64'd0);
      end
      check_eq("postrst_busy", 64'(busy), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
